// File: rtl/key_shift_entry_if.sv
// Front-panel entry bus: raw keys and direction in, entry register state out.
// The panel side drives keys/dir (master); the entry block owns the results (slave).
interface key_shift_entry_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       key_n;
    logic             dir;
    logic [WIDTH-1:0] value;
    logic [CW-1:0]    count;
    logic             full;
    logic             update;

    modport master (
        output key_n, dir,
        input  value, count, full, update
    );

    modport slave (
        input  key_n, dir,
        output value, count, full, update
    );
endinterface

// File: rtl/key_shift_entry.sv
// Two-key binary entry: sync, debounce, chord window, shift/clear register.
// Optional auto-repeat of held single keys under KEY_SHIFT_AUTOREPEAT_EN.
module key_shift_entry #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CHORD_CYCLES    = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic               clock_50,
    input  logic               reset_n,
    key_shift_entry_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef KEY_SHIFT_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMAX = (RMAX > CHORD_CYCLES) ? RMAX : CHORD_CYCLES;
`else
    localparam int TMAX = CHORD_CYCLES;
`endif
    localparam int TW = $clog2(TMAX + 1);

    if (WIDTH < 2 || DEBOUNCE_CYCLES < 1 || CHORD_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_chk
        $error("key_shift_entry: invalid parameter");
    end

    typedef enum logic [1:0] {IDLE, ARM, HELD} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [DW-1:0]    cnt_q [2];
    logic [DW-1:0]    cnt_d [2];
    logic [1:0]       chord_q, chord_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    count_q, count_d;
    logic             update_q, update_d;
    logic             commit;
    logic [1:0]       cmt_chord;
    logic             bit_in;
`ifdef KEY_SHIFT_AUTOREPEAT_EN
    logic             rpt_live_q, rpt_live_d;
    logic             rpt_first_q, rpt_first_d;
    logic [TW-1:0]    rpt_lim;
`endif

    always_comb begin
        sync1_d = ~bus.key_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        state_d   = state_q;
        chord_d   = chord_q;
        timer_d   = timer_q;
        value_d   = value_q;
        count_d   = count_q;
        update_d  = 1'b0;
        commit    = 1'b0;
        cmt_chord = chord_q;
        bit_in    = 1'b0;
`ifdef KEY_SHIFT_AUTOREPEAT_EN
        rpt_live_d  = rpt_live_q;
        rpt_first_d = rpt_first_q;
        rpt_lim     = rpt_first_q ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1);
`endif

        unique case (state_q)
            IDLE: begin
                if (deb_q != 2'b00) begin
                    state_d = ARM;
                    chord_d = deb_q;
                    timer_d = '0;
                end
            end
            ARM: begin
                chord_d = chord_q | deb_q;
                if (timer_q == TW'(CHORD_CYCLES - 1)) begin
                    commit    = 1'b1;
                    cmt_chord = chord_d;
                    state_d   = HELD;
                    timer_d   = '0;
`ifdef KEY_SHIFT_AUTOREPEAT_EN
                    rpt_live_d  = (chord_d != 2'b11);
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HELD: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
`ifdef KEY_SHIFT_AUTOREPEAT_EN
                    rpt_live_d = 1'b0;
                end else if (rpt_live_q) begin
                    // any deviation from the committed key ends repeating for this press
                    if (deb_q != chord_q) begin
                        rpt_live_d = 1'b0;
                    end else if (timer_q == rpt_lim) begin
                        commit      = 1'b1;
                        timer_d     = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            update_d = 1'b1;
            bit_in   = (cmt_chord == 2'b01);
            if (cmt_chord == 2'b11) begin
                value_d = '0;
                count_d = '0;
            end else begin
                value_d = bus.dir ? {bit_in, value_q[WIDTH-1:1]}
                                  : {value_q[WIDTH-2:0], bit_in};
                if (count_q != CW'(WIDTH)) count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            chord_q  <= '0;
            timer_q  <= '0;
            value_q  <= '0;
            count_q  <= '0;
            update_q <= 1'b0;
`ifdef KEY_SHIFT_AUTOREPEAT_EN
            rpt_live_q  <= 1'b0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            chord_q  <= chord_d;
            timer_q  <= timer_d;
            value_q  <= value_d;
            count_q  <= count_d;
            update_q <= update_d;
`ifdef KEY_SHIFT_AUTOREPEAT_EN
            rpt_live_q  <= rpt_live_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign bus.value  = value_q;
    assign bus.count  = count_q;
    assign bus.full   = (count_q == CW'(WIDTH));
    assign bus.update = update_q;
endmodule
